// File: rtl/cpu_irq_ctrl.sv
// cpu_irq_ctrl
//   Interrupt request controller feeding the CPU exception unit. External
//   interrupt lines are synchronised and latched as edge- or level-sensitive
//   pending bits. The pending bits are masked by ENABLE, and the lowest
//   eligible index is presented as a single registered request with a cause
//   code. An accepted acknowledge retires the request. After that the
//   controller spends one GAP cycle before it looks for the next request.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   stall      in   pipeline stall; register writes and acks ignored while high
//   irq_src    in   raw asynchronous interrupt lines, active-high
//   reg_wr     in   register write strobe
//   reg_rd     in   register read strobe
//   reg_addr   in   0 ENABLE, 1 EDGE, 2 PENDING (W1C), 3 ACTIVE (read-only)
//   reg_wdata  in   write data, bits [NUM_SRC-1:0] used
//   reg_rdata  out  registered read data, valid the cycle after reg_rd
//   irq_req    out  registered interrupt request
//   irq_cause  out  registered cause, stable while irq_req is high
//   irq_ack    in   exception unit has vectored to the handler
module cpu_irq_ctrl #(
  parameter int          NUM_SRC     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CAUSE_BASE  = 8'h10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq_req,
  output logic [7:0]         irq_cause,
  input  logic               irq_ack
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_ACTIVE  = 2'd3;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sd_q;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [7:0]         active_q, active_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               req_q, req_d;
  logic [7:0]         cause_q, cause_d;
  logic [3:0]         idx_q, idx_d;
  state_e             state_q, state_d;

  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] elig;
  logic               wr_ok;
  logic               ack_ok;
  logic               pick_vld;
  logic [3:0]         pick_idx;
  logic               wdata_unused;

  // Only the low NUM_SRC write-data bits carry register state.
  assign wdata_unused = ^reg_wdata[31:NUM_SRC];

  // Synchroniser chain plus one extra stage for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      sd_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      sd_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~sd_q;
  assign wr_ok  = reg_wr & ~stall;
  assign ack_ok = (state_q == REQ) & irq_ack & ~stall;
  assign w1c    = (wr_ok && reg_addr == ADDR_PENDING) ? reg_wdata[NUM_SRC-1:0] : '0;
  assign elig   = pend_q & enable_q;

  // The request index is kept alongside the cause, so the ack clears
  // exactly the bit that was reported.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) ack_clr[i] = ack_ok && (idx_q == 4'(i));
  end

  // Edge bits: a rise beats any clear in the same cycle. Level bits mirror s.
  assign pend_d = (edge_q & ((pend_q & ~(w1c | ack_clr)) | rise)) | (~edge_q & s);

  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_vld = 1'b1;
        pick_idx = 4'(i);
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    if (wr_ok && reg_addr == ADDR_ENABLE) enable_d = reg_wdata[NUM_SRC-1:0];
    if (wr_ok && reg_addr == ADDR_EDGE)   edge_d   = reg_wdata[NUM_SRC-1:0];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (reg_rd) begin
      case (reg_addr)
        ADDR_ENABLE:  rdata_d = 32'(enable_q);
        ADDR_EDGE:    rdata_d = 32'(edge_q);
        ADDR_PENDING: rdata_d = 32'(pend_q);
        ADDR_ACTIVE:  rdata_d = {24'h0, active_q};
        default:      rdata_d = '0;
      endcase
    end
  end

  // Request FSM. Once in REQ, the request is held until an accepted ack,
  // whatever happens to ENABLE or PENDING meanwhile.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cause_d  = cause_q;
    idx_d    = idx_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          cause_d = CAUSE_BASE + {4'h0, pick_idx};
          idx_d   = pick_idx;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_ok) begin
          req_d    = 1'b0;
          active_d = cause_q;
          state_d  = GAP;
        end
      end
      GAP: begin
        // Forces a deasserted cycle so the next request is seen as new.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      active_q <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      cause_q  <= '0;
      idx_q    <= '0;
      state_q  <= IDLE;
    end else begin
      enable_q <= enable_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      cause_q  <= cause_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign irq_req   = req_q;
  assign irq_cause = cause_q;

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
module tb_cpu_irq_ctrl;
  localparam int         NS   = 8;
  localparam int         S    = 2;
  localparam logic [7:0] BASE = 8'h10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic [NS-1:0] irq_src = '0;
  logic          reg_wr = 1'b0;
  logic          reg_rd = 1'b0;
  logic [1:0]    reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic [31:0]   reg_rdata;
  logic          irq_req;
  logic [7:0]    irq_cause;
  logic          irq_ack = 1'b0;

  cpu_irq_ctrl #(.NUM_SRC(NS), .SYNC_STAGES(S), .CAUSE_BASE(BASE)) dut (
    .clock(clock), .reset(reset), .stall(stall), .irq_src(irq_src),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: delayed copies of the raw lines, the pending/enable
  // sets and a request/gap flag pair, advanced once per clock edge.
  logic [NS-1:0] m_hist [0:S];
  logic [NS-1:0] m_en, m_edge, m_pend;
  logic [7:0]    m_active, m_cause;
  logic          m_req, m_gap;
  logic [31:0]   m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k <= S; k++) m_hist[k] = '0;
    m_en = '0; m_edge = '0; m_pend = '0;
    m_active = '0; m_cause = '0; m_req = 1'b0; m_gap = 1'b0; m_rdata = '0;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    logic [NS-1:0] lvl, rise, newp;
    logic wr_ok, ack_ok;
    int first;
    if (!reset) begin
      model_reset();
      return;
    end
    lvl    = m_hist[S-1];
    rise   = lvl & ~m_hist[S];
    wr_ok  = reg_wr && !stall;
    ack_ok = m_req && irq_ack && !stall;
    for (int i = 0; i < NS; i++) begin
      if (m_edge[i]) begin
        if (rise[i]) newp[i] = 1'b1;
        else if ((wr_ok && reg_addr == 2'd2 && reg_wdata[i]) ||
                 (ack_ok && m_cause == BASE + 8'(i))) newp[i] = 1'b0;
        else newp[i] = m_pend[i];
      end else begin
        newp[i] = lvl[i];
      end
    end
    if (reg_rd) begin
      case (reg_addr)
        2'd0: m_rdata = 32'(m_en);
        2'd1: m_rdata = 32'(m_edge);
        2'd2: m_rdata = 32'(m_pend);
        default: m_rdata = {24'h0, m_active};
      endcase
    end
    first = -1;
    for (int i = NS - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) first = i;
    if (m_req) begin
      if (ack_ok) begin
        m_req = 1'b0; m_active = m_cause; m_gap = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (first >= 0) begin
      m_req = 1'b1; m_cause = BASE + 8'(first);
    end
    if (wr_ok && reg_addr == 2'd0) m_en   = reg_wdata[NS-1:0];
    if (wr_ok && reg_addr == 2'd1) m_edge = reg_wdata[NS-1:0];
    m_pend = newp;
    for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = irq_src;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("req_vs_model", 32'(irq_req), 32'(m_req));
    chk("cause_vs_model", 32'(irq_cause), 32'(m_cause));
    chk("rdata_vs_model", reg_rdata, m_rdata);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    reg_rd = 1'b1; reg_addr = a;
    tick();
    reg_rd = 1'b0;
    chk(tag, reg_rdata, exp);
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!irq_req && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(irq_req), 32'd1);
  endtask

  initial begin
    int n;
    model_reset();
    // Reset state
    tick(); tick();
    chk("reset_req", 32'(irq_req), 32'd0);
    chk("reset_cause", 32'(irq_cause), 32'd0);
    chk("reset_rdata", reg_rdata, 32'd0);
    reset = 1'b1;
    tick();

    // 1: single edge source, latency and ack
    wr_reg(2'd1, 32'h01);
    wr_reg(2'd0, 32'h01);
    irq_src = 8'h01;
    tick();
    irq_src = '0;
    wait_req("t1_req", n);
    chk("t1_latency", 32'(n + 1), 32'(S + 2));
    chk("t1_cause", 32'(irq_cause), 32'h10);
    do_ack();
    chk("t1_req_after_ack", 32'(irq_req), 32'd0);
    rd_chk("t1_pending", 2'd2, 32'h0);
    rd_chk("t1_active", 2'd3, 32'h10);

    // 2: simultaneous edges, priority and gap
    wr_reg(2'd1, 32'h0C);
    wr_reg(2'd0, 32'h0C);
    irq_src = 8'h0C;
    tick();
    irq_src = '0;
    wait_req("t2_req1", n);
    chk("t2_cause1", 32'(irq_cause), 32'h12);
    do_ack();
    chk("t2_gap", 32'(irq_req), 32'd0);
    wait_req("t2_req2", n);
    chk("t2_cause2", 32'(irq_cause), 32'h13);
    do_ack();
    rd_chk("t2_pending", 2'd2, 32'h0);

    // 3: level source re-requests while held
    wr_reg(2'd1, 32'h00);
    wr_reg(2'd0, 32'h20);
    irq_src = 8'h20;
    wait_req("t3_req1", n);
    chk("t3_cause1", 32'(irq_cause), 32'h15);
    do_ack();
    wait_req("t3_req2", n);
    chk("t3_cause2", 32'(irq_cause), 32'h15);
    irq_src = '0;
    repeat (S + 2) tick();
    do_ack();
    repeat (8) tick();
    chk("t3_no_rereq", 32'(irq_req), 32'd0);

    // 4: request held through mask and clear
    wr_reg(2'd1, 32'h02);
    wr_reg(2'd0, 32'h02);
    irq_src = 8'h02;
    tick();
    irq_src = '0;
    wait_req("t4_req", n);
    wr_reg(2'd0, 32'h00);
    wr_reg(2'd2, 32'h02);
    tick();
    chk("t4_req_held", 32'(irq_req), 32'd1);
    chk("t4_cause_held", 32'(irq_cause), 32'h11);
    do_ack();
    chk("t4_req_after_ack", 32'(irq_req), 32'd0);

    // 5: ack and writes ignored while stalled
    wr_reg(2'd0, 32'h02);
    irq_src = 8'h02;
    tick();
    irq_src = '0;
    wait_req("t5_req", n);
    stall = 1'b1; irq_ack = 1'b1;
    tick();
    chk("t5_stall_ack", 32'(irq_req), 32'd1);
    reg_wr = 1'b1; reg_addr = 2'd2; reg_wdata = 32'h02;
    tick();
    reg_wr = 1'b0;
    rd_chk("t5_pending_stall", 2'd2, 32'h02);
    stall = 1'b0;
    tick();
    irq_ack = 1'b0;
    chk("t5_req_unstall", 32'(irq_req), 32'd0);
    rd_chk("t5_pending_after", 2'd2, 32'h0);

    // 6: set beats W1C in the same cycle, then reset mid-request
    repeat (3) tick();
    wr_reg(2'd1, 32'h01);
    wr_reg(2'd0, 32'h01);
    irq_src = 8'h01;
    tick();
    tick();
    reg_wr = 1'b1; reg_addr = 2'd2; reg_wdata = 32'h01;
    tick();
    reg_wr = 1'b0;
    irq_src = '0;
    rd_chk("t6_set_wins", 2'd2, 32'h01);
    chk("t6_req", 32'(irq_req), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_async_req", 32'(irq_req), 32'd0);
    chk("t6_async_cause", 32'(irq_cause), 32'd0);
    chk("t6_async_rdata", reg_rdata, 32'd0);
    tick();
    reset = 1'b1;
    rd_chk("t6_enable0", 2'd0, 32'h0);
    rd_chk("t6_edge0", 2'd1, 32'h0);
    rd_chk("t6_pending0", 2'd2, 32'h0);
    rd_chk("t6_active0", 2'd3, 32'h0);

    // Randomised traffic against the model
    wr_reg(2'd1, 32'($urandom));
    wr_reg(2'd0, 32'($urandom));
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ NS'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      irq_ack   = ($urandom_range(0, 2) == 0);
      reg_wr    = ($urandom_range(0, 7) == 0);
      reg_rd    = ($urandom_range(0, 2) == 0);
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpu_irq_ctrl.md
Name: cpu_irq_ctrl

Overview:
Interrupt controller on the request side of the CPU exception unit's interrupt interface. It collects external interrupt lines, synchronises them, and latches them as edge- or level-sensitive pending bits. It then masks them, picks one by fixed priority, and presents a single request plus cause code to the exception unit. When the exception unit vectors to the handler it returns an acknowledge, and that acknowledge retires the request. Software configures the block through a small register port driven from the P3 stage.

Parameters:
NUM_SRC, 8, number of interrupt source lines (1..16).
SYNC_STAGES, 2, flip-flop synchroniser depth per source (>=2).
CAUSE_BASE, 8'h10, cause code reported for source 0. Source i reports CAUSE_BASE+i.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  pipeline stall; register writes and acks are ignored while high.
irq_src  input  NUM_SRC  raw asynchronous interrupt lines, active-high.
reg_wr  input  1  register write strobe.
reg_rd  input  1  register read strobe.
reg_addr  input  2  register select: 0 ENABLE, 1 EDGE, 2 PENDING, 3 ACTIVE.
reg_wdata  input  32  write data; only bits [NUM_SRC-1:0] are used.
reg_rdata  output  32  read data, registered, valid one cycle after reg_rd.
irq_req  output  1  interrupt request to the exception unit, registered.
irq_cause  output  8  cause of the current request, registered, stable while irq_req=1.
irq_ack  input  1  exception unit has taken the interrupt (vectored to intvec).

Behaviour:
- Reset (reset=0, asynchronous): all synchroniser flops, ENABLE, EDGE, PENDING and ACTIVE go to 0; irq_req=0; irq_cause=0; reg_rdata=0; FSM goes to IDLE.
- Synchroniser: each irq_src bit passes through SYNC_STAGES flops. The synchronised value is s[i]; the value one cycle earlier is s_d[i].
- Pending, edge source (EDGE[i]=1):
  - PENDING[i] sets on a rising edge (s[i]=1, s_d[i]=0).
  - It clears on a PENDING write with wdata[i]=1 (write-1-to-clear), or on an accepted ack whose cause selects i.
  - If a set and a clear land in the same cycle, set wins.
- Pending, level source (EDGE[i]=0): PENDING[i]=s[i] every cycle. Writes and acks have no effect on it; the handler must quiet the device.
- Latency: an input edge or level reaches PENDING SYNC_STAGES+1 cycles after irq_src. irq_req follows one cycle later.
- Register writes take effect only when reg_wr=1 and stall=0. ACTIVE is read-only; writes to it are ignored.
- Read mux: ENABLE, EDGE and PENDING read zero-extended. ACTIVE reads {24'h0, last acked cause}, updated on each accepted ack.
- Eligible set: E = PENDING & ENABLE. Priority: lowest index wins.
- FSM:
  - IDLE: if E!=0, load irq_cause = CAUSE_BASE + index of the lowest set bit of E, set irq_req=1, go to REQ.
  - REQ: irq_req and irq_cause are held even if the source is later masked or cleared; a request is never withdrawn.
    - An accepted ack (irq_ack=1 and stall=0) sets irq_req=0, updates ACTIVE, clears the edge pending bit if applicable, and moves to GAP.
    - irq_ack while stall=1 is ignored.
  - GAP: one cycle with irq_req=0, then go to IDLE. This guarantees at least one deasserted cycle between requests, which the exception unit needs to see a fresh request.
- irq_ack outside REQ is ignored.
- The cause width is 8 bits, and CAUSE_BASE+i must not wrap. With NUM_SRC<=16 and base 8'h10, the maximum cause is 8'h1F.
- A reset assertion mid-REQ drops irq_req asynchronously. No ack is expected afterwards.

Test Plan:
1. Reset, ENABLE=0x01, EDGE=0x01, pulse irq_src[0] for 1 cycle -> irq_req rises SYNC_STAGES+2 cycles later with irq_cause=0x10. Ack -> irq_req=0, PENDING=0, ACTIVE=0x10.
2. ENABLE=0x0C, EDGE=0x0C, edges on src2 and src3 in the same cycle -> first request has cause 0x12. Ack, one GAP cycle with irq_req=0, then cause 0x13. Ack -> PENDING=0.
3. Level source 5 (EDGE=0, ENABLE=0x20), irq_src[5] held high -> cause 0x15. Ack with the source still high -> after GAP, re-request 0x15. Drop the source, ack -> no further request.
4. Edge on src1 (ENABLE=0x02, EDGE=0x02), then while in REQ write ENABLE=0 and write PENDING=0x02 -> irq_req stays 1 with cause 0x11 until ack.
5. In REQ, assert irq_ack with stall=1 -> irq_req stays 1. Deassert stall with ack high -> irq_req=0 next cycle. A PENDING write during stall has no effect.
6. Edge on src0 in the same cycle as a PENDING W1C of bit 0 -> PENDING[0]=1 (set wins). Assert reset mid-REQ -> irq_req=0 immediately and all registers read 0.
